// File: rtl/fp32_to_fp16_pipe_if.sv
// Operand/result stream bundle for the binary32 -> binary16 converter.
// The producer side drives valid_i/fp32_i, the consumer side drives ready_i, and either side may drive clear_i.
interface fp32_to_fp16_pipe_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] fp32_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] fp16_o;
  logic [3:0]  flags_o;
  logic        clear_i;
  logic [3:0]  sticky_flags_o;

  modport master (
    output valid_i, fp32_i, ready_i, clear_i,
    input  ready_o, valid_o, fp16_o, flags_o, sticky_flags_o
  );

  modport slave (
    input  valid_i, fp32_i, ready_i, clear_i,
    output ready_o, valid_o, fp16_o, flags_o, sticky_flags_o
  );
endinterface

// File: rtl/fp32_to_fp16_pipe.sv
// Two-stage IEEE 754 binary32 -> binary16 converter with round-to-nearest-even and exception flags.
// S1 unpacks, classifies and aligns the significand; S2 rounds, packs and registers all outputs.
module fp32_to_fp16_pipe #(
  parameter bit SATURATE = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  fp32_to_fp16_pipe_if.slave bus
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // A producer holding valid keeps its data stable until the transfer; ready never depends on valid_i.
  typedef enum logic [1:0] {
    K_FINITE = 2'd0,
    K_OVF    = 2'd1,
    K_FIXED  = 2'd2
  } kind_t;

  logic        s1_valid;
  logic        s1_sign;
  kind_t       s1_kind;
  logic [4:0]  s1_exp;
  logic [9:0]  s1_man;
  logic        s1_guard;
  logic        s1_sticky;
  logic        s1_tiny;
  logic [14:0] s1_fixed_mag;
  logic [3:0]  s1_fixed_flags;

  logic        valid_q;
  logic [15:0] fp16_q;
  logic [3:0]  flags_q;
  logic [3:0]  sticky_q;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv = !valid_q || bus.ready_i;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.ready_o        = s1_adv;
  assign bus.valid_o        = valid_q;
  assign bus.fp16_o         = fp16_q;
  assign bus.flags_o        = flags_q;
  assign bus.sticky_flags_o = sticky_q;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic [23:0] sig;
  logic [7:0]  sub_amt;
  logic [49:0] sub_wide;

  kind_t       c_kind;
  logic [4:0]  c_exp;
  logic [9:0]  c_man;
  logic        c_guard;
  logic        c_sticky;
  logic        c_tiny;
  logic [14:0] c_fixed_mag;
  logic [3:0]  c_fixed_flags;

  assign in_sign = bus.fp32_i[31];
  assign in_exp  = bus.fp32_i[30:23];
  assign in_man  = bus.fp32_i[22:0];
  assign sig     = {1'b1, in_man};

  // Subnormal alignment: the 10-bit field is {1,man} >> (shift+13) where shift = 113-exp.
  // Shifts past 26 are clamped; everything then lands below the guard bit and only feeds sticky.
  always_comb begin
    sub_amt  = (in_exp <= 8'd87) ? 8'd39 : (8'd126 - in_exp);
    sub_wide = 50'({sig, 40'b0} >> sub_amt);
  end

  always_comb begin
    c_kind        = K_FINITE;
    c_exp         = 5'd0;
    c_man         = 10'd0;
    c_guard       = 1'b0;
    c_sticky      = 1'b0;
    c_tiny        = 1'b0;
    c_fixed_mag   = 15'h0000;
    c_fixed_flags = 4'b0000;
    if (in_exp == 8'hFF) begin
      c_kind = K_FIXED;
      if (in_man == 23'd0) begin
        c_fixed_mag = 15'h7C00;
      end else begin
        c_fixed_mag   = 15'h7E00;
        c_fixed_flags = {~in_man[22], 3'b000};
      end
    end else if (in_exp == 8'h00) begin
      c_kind        = K_FIXED;
      c_fixed_flags = {2'b00, |in_man, |in_man};
    end else if (in_exp > 8'd142) begin
      c_kind = K_OVF;
    end else if (in_exp >= 8'd113) begin
      // Rebias by 127-15 = 112; exp 113..142 maps to 1..30, so only the low 5 bits matter.
      c_exp    = in_exp[4:0] - 5'd16;
      c_man    = in_man[22:13];
      c_guard  = in_man[12];
      c_sticky = |in_man[11:0];
    end else begin
      c_tiny   = 1'b1;
      c_man    = sub_wide[49:40];
      c_guard  = sub_wide[39];
      c_sticky = |sub_wide[38:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && s1_adv && bus.valid_i) begin
      s1_sign        <= in_sign;
      s1_kind        <= c_kind;
      s1_exp         <= c_exp;
      s1_man         <= c_man;
      s1_guard       <= c_guard;
      s1_sticky      <= c_sticky;
      s1_tiny        <= c_tiny;
      s1_fixed_mag   <= c_fixed_mag;
      s1_fixed_flags <= c_fixed_flags;
    end
  end

  logic        round_up;
  logic        inexact;
  logic [14:0] rnd_sum;
  logic [14:0] ovf_mag;
  logic [15:0] r_fp16;
  logic [3:0]  r_flags;

  assign ovf_mag = SATURATE ? 15'h7BFF : 15'h7C00;

  // Rounding on the packed {exp,man} word lets a mantissa carry ripple into the exponent,
  // which covers both subnormal->normal promotion and normal->overflow.
  always_comb begin
    round_up = s1_guard && (s1_sticky || s1_man[0]);
    inexact  = s1_guard || s1_sticky;
    rnd_sum  = {s1_exp, s1_man} + {14'd0, round_up};
    r_fp16   = {s1_sign, 15'h0000};
    r_flags  = 4'b0000;
    case (s1_kind)
      K_FIXED: begin
        r_fp16  = {s1_sign, s1_fixed_mag};
        r_flags = s1_fixed_flags;
      end
      K_OVF: begin
        r_fp16  = {s1_sign, ovf_mag};
        r_flags = 4'b0101;
      end
      default: begin
        if (rnd_sum[14:10] == 5'h1F) begin
          r_fp16  = {s1_sign, ovf_mag};
          r_flags = 4'b0101;
        end else begin
          r_fp16  = {s1_sign, rnd_sum};
          r_flags = {2'b00, s1_tiny && inexact, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      fp16_q   <= 16'h0000;
      flags_q  <= 4'b0000;
      sticky_q <= 4'b0000;
    end else begin
      if (s2_adv) begin
        valid_q <= s1_valid;
        if (s1_valid) begin
          fp16_q  <= r_fp16;
          flags_q <= r_flags;
        end
      end
      if (valid_q && bus.ready_i) begin
        sticky_q <= bus.clear_i ? flags_q : (sticky_q | flags_q);
      end else if (bus.clear_i) begin
        sticky_q <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// Bench for fp32_to_fp16_pipe: directed vectors, backpressure, sticky/reset scenarios and
// randomized traffic, all checked against an arithmetic reference model (both SATURATE settings).
module tb_fp32_to_fp16_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_to_fp16_pipe_if ifc ();
  fp32_to_fp16_pipe_if ifs ();

  fp32_to_fp16_pipe #(.SATURATE(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  fp32_to_fp16_pipe #(.SATURATE(1'b1)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifs.slave)
  );

  assign ifs.valid_i = ifc.valid_i;
  assign ifs.fp32_i  = ifc.fp32_i;
  assign ifs.ready_i = ifc.ready_i;
  assign ifs.clear_i = ifc.clear_i;

  int checks = 0;
  int errors = 0;

  // Entries are {fp16 with SATURATE=1, fp16 with SATURATE=0, flags}.
  logic [35:0] exp_q[$];
  logic [3:0]  sticky_m = 4'b0000;
  logic        hold_prev = 1'b0;
  logic [19:0] held = 20'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Value = sig * 2^(e-150); divide by the binary16 quantum of its binade and round to nearest-even.
  function automatic logic [19:0] model(input logic [31:0] x, input bit sat);
    logic        s;
    int          e, unb, d;
    logic [22:0] m;
    longint      sig, q, r, half, n, mag;
    bit          inexact, up, tiny;
    s = x[31];
    e = int'(x[30:23]);
    m = x[22:0];
    if (e == 255) return (m == 23'd0) ? {s, 15'h7C00, 4'h0} : {s, 15'h7E00, ~m[22], 3'b000};
    if (e == 0) return {s, 15'h0000, 2'b00, m != 23'd0, m != 23'd0};
    unb  = e - 127;
    sig  = longint'({1'b1, m});
    tiny = unb < -14;
    d    = tiny ? (13 + (-14 - unb)) : 13;
    if (d >= 40) begin
      n = 0;
      inexact = 1'b1;
    end else begin
      q       = sig >> d;
      r       = sig - (q << d);
      half    = longint'(1) << (d - 1);
      inexact = r != 0;
      up      = (r > half) || ((r == half) && q[0]);
      n       = q + (up ? 1 : 0);
    end
    mag = tiny ? n : (longint'(unb + 14) * 1024 + n);
    if (unb > 15 || mag >= 31 * 1024) return {s, sat ? 15'h7BFF : 15'h7C00, 4'b0101};
    return {s, mag[14:0], 2'b00, tiny && inexact, inexact};
  endfunction

  always @(negedge clk) begin
    logic [35:0] e;
    logic [19:0] m0, m1;
    if (rst) begin
      exp_q.delete();
      sticky_m  = 4'b0000;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", ifc.valid_o, 1);
        check("hold_data", {ifc.fp16_o, ifc.flags_o}, held);
      end
      check("sticky", ifc.sticky_flags_o, sticky_m);
      check("sticky_sat", ifs.sticky_flags_o, sticky_m);
      if (ifc.valid_o && ifc.ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no output", ifc.fp16_o);
        end else begin
          e = exp_q.pop_front();
          check("fp16", ifc.fp16_o, e[19:4]);
          check("flags", ifc.flags_o, e[3:0]);
          check("sat_valid", ifs.valid_o, 1);
          check("sat_fp16", ifs.fp16_o, e[35:20]);
          sticky_m = ifc.clear_i ? e[3:0] : (sticky_m | e[3:0]);
        end
      end else if (ifc.clear_i) begin
        sticky_m = 4'b0000;
      end
      hold_prev = ifc.valid_o && !ifc.ready_i;
      held      = {ifc.fp16_o, ifc.flags_o};
      if (ifc.valid_i && ifc.ready_o) begin
        m0 = model(ifc.fp32_i, 1'b0);
        m1 = model(ifc.fp32_i, 1'b1);
        exp_q.push_back({m1[19:4], m0});
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c,
                      output logic acc, output logic vo);
    ifc.valid_i = v;
    ifc.fp32_i  = d;
    ifc.ready_i = r;
    ifc.clear_i = c;
    @(negedge clk);
    acc = v && ifc.ready_o;
    vo  = ifc.valid_o;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    logic [7:0]  ex;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: ex = x[30:23];
      1: ex = 8'($urandom_range(100, 145));
      2: ex = 8'($urandom_range(101, 113));
      3: ex = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      4: begin
        ex = 8'($urandom_range(113, 142));
        x[12:0] = 13'h1000;
      end
      default: ex = 8'($urandom_range(141, 143));
    endcase
    if ($urandom_range(0, 3) == 0) x[22:0] = 23'd0;
    return {x[31], ex, x[22:0]};
  endfunction

  typedef struct {
    logic [31:0] in;
    logic [19:0] out;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic        acc, vo;
    logic [31:0] ops[4];
    logic [19:0] mm;
    int          idx;
    logic        pend;
    logic [31:0] pdat;

    vecs[0]  = '{32'h3F800000, {16'h3C00, 4'h0}};
    vecs[1]  = '{32'h477FE000, {16'h7BFF, 4'h0}};
    vecs[2]  = '{32'h3F801000, {16'h3C00, 4'h1}};
    vecs[3]  = '{32'h3F803000, {16'h3C02, 4'h1}};
    vecs[4]  = '{32'h477FF000, {16'h7C00, 4'h5}};
    vecs[5]  = '{32'h33800000, {16'h0001, 4'h0}};
    vecs[6]  = '{32'h33000000, {16'h0000, 4'h3}};
    vecs[7]  = '{32'h80000000, {16'h8000, 4'h0}};
    vecs[8]  = '{32'h7F800001, {16'h7E00, 4'h8}};
    vecs[9]  = '{32'hFFC00000, {16'hFE00, 4'h0}};
    vecs[10] = '{32'hFF800000, {16'hFC00, 4'h0}};
    vecs[11] = '{32'h387FF000, {16'h0400, 4'h3}};

    ifc.valid_i = 1'b0;
    ifc.fp32_i  = 32'd0;
    ifc.ready_i = 1'b0;
    ifc.clear_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid_o", ifc.valid_o, 0);
    check("rst_fp16_o", ifc.fp16_o, 16'h0000);
    check("rst_flags_o", ifc.flags_o, 4'h0);
    check("rst_sticky", ifc.sticky_flags_o, 4'h0);
    check("rst_ready_o", ifc.ready_o, 1);

    for (int i = 0; i < 12; i++) begin
      mm = model(vecs[i].in, 1'b0);
      check($sformatf("model_vec%0d", i), mm, vecs[i].out);
    end
    mm = model(32'h477FF000, 1'b1);
    check("model_sat_ovf", mm, {16'h7BFF, 4'h5});

    step(1'b1, 32'h3F800000, 1'b1, 1'b0, acc, vo);
    check("lat_accept", acc, 1);
    check("lat_cycle1", ifc.valid_o, 0);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
    check("lat_cycle2", ifc.valid_o, 1);
    check("lat_fp16", ifc.fp16_o, 16'h3C00);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);

    for (int i = 0; i < 12; i++) step(1'b1, vecs[i].in, 1'b1, 1'b0, acc, vo);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);

    ops[0] = 32'h3F800000;
    ops[1] = 32'h3F803000;
    ops[2] = 32'h40000000;
    ops[3] = 32'hC0400000;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(idx < 4, ops[idx % 4], 1'b0, 1'b0, acc, vo);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_ready_low", ifc.ready_o, 0);
    check("bp_head", ifc.fp16_o, 16'h3C00);
    for (int k = 0; k < 4; k++) begin
      step(idx < 4, ops[idx % 4], 1'b1, 1'b0, acc, vo);
      check("bp_drain_valid", vo, 1);
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 4);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);

    step(1'b0, 32'd0, 1'b1, 1'b1, acc, vo);
    step(1'b1, 32'h7F000000, 1'b1, 1'b0, acc, vo);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
    check("sticky_ovf", ifc.sticky_flags_o, 4'b0101);
    step(1'b1, 32'h3F801000, 1'b1, 1'b0, acc, vo);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
    step(1'b0, 32'd0, 1'b1, 1'b1, acc, vo);
    check("sticky_clear_xfer", ifc.sticky_flags_o, 4'b0001);

    step(1'b1, 32'h40400000, 1'b1, 1'b0, acc, vo);
    step(1'b1, 32'h40800000, 1'b1, 1'b0, acc, vo);
    rst = 1'b1;
    step(1'b1, 32'h3F800000, 1'b1, 1'b1, acc, vo);
    rst = 1'b0;
    check("midrst_valid_o", ifc.valid_o, 0);
    check("midrst_ready_o", ifc.ready_o, 1);
    check("midrst_sticky", ifc.sticky_flags_o, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
      check("midrst_no_output", vo, 0);
    end

    pend = 1'b0;
    pdat = 32'd0;
    for (int k = 0; k < 800; k++) begin
      if (!pend) begin
        pend = $urandom_range(0, 3) != 0;
        pdat = rand_operand();
      end
      step(pend, pdat, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc, vo);
      if (acc) pend = 1'b0;
    end
    repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0, acc, vo);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
